// File: rtl/uart_tx_fifo_if.sv
// Host-side bus of the buffered UART transmitter: write strobe, status flags,
// the serial line, and the FSM state for observation.
interface uart_tx_fifo_if;
  logic [7:0] data_i;
  logic       ack_i;
  logic       tx;
  logic       full_o;
  logic       empty_o;
  logic       busy_o;
  logic       overflow_o;
  logic [1:0] dbg_state;

  // Handshake: ack_i is a one-cycle write strobe with no ready; a strobe seen
  // while full_o=1 is discarded and latches overflow_o until reset.
  modport master (
    output data_i, ack_i,
    input  tx, full_o, empty_o, busy_o, overflow_o, dbg_state
  );

  modport slave (
    input  data_i, ack_i,
    output tx, full_o, empty_o, busy_o, overflow_o, dbg_state
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: a power-of-two FIFO feeds a start/data/stop
// serializer that shifts bytes out LSB-first at CLK_DIV clocks per bit.
module uart_tx_fifo #(
  parameter int CLK_DIV         = 434,
  parameter int FIFO_DEPTH_LOG2 = 3
) (
  input logic           clk,
  input logic           rst_n,
  uart_tx_fifo_if.slave bus
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int BW    = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int CW    = FIFO_DEPTH_LOG2 + 1;
  localparam logic [BW-1:0] BAUD_LOAD  = BW'(CLK_DIV - 1);
  localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t                     r_state;
  logic                       r_tx;
  logic                       r_busy;
  logic                       r_overflow;
  logic                       r_full;
  logic                       r_empty;
  logic [FIFO_DEPTH_LOG2-1:0] r_wr_ptr;
  logic [FIFO_DEPTH_LOG2-1:0] r_rd_ptr;
  logic [CW-1:0]              r_count;
  logic [BW-1:0]              r_baud;
  logic [2:0]                 r_bit_idx;
  logic [7:0]                 r_shift;
  logic [7:0]                 r_mem [DEPTH];

  logic          w_wr;
  logic          w_pop;
  logic          w_baud_zero;
  logic [CW-1:0] w_count_nxt;
  logic [7:0]    w_head;

  // Full is the registered pre-edge status, so a same-cycle pop never frees room for a write.
  assign w_wr        = bus.ack_i & ~r_full;
  assign w_baud_zero = (r_baud == '0);
  assign w_pop       = ~r_empty & ((r_state == S_IDLE) | ((r_state == S_STOP) & w_baud_zero));
  assign w_count_nxt = r_count + CW'(w_wr) - CW'(w_pop);
  assign w_head      = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= bus.data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (bus.ack_i & r_full) begin
        r_overflow <= 1'b1;
      end
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == COUNT_FULL);
      r_empty <= (w_count_nxt == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
      r_baud    <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_tx   <= 1'b1;
          r_busy <= 1'b0;
          if (w_pop) begin
            r_shift <= w_head;
            r_baud  <= BAUD_LOAD;
            r_tx    <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (w_baud_zero) begin
            r_state   <= S_DATA;
            r_bit_idx <= '0;
            r_baud    <= BAUD_LOAD;
            r_tx      <= r_shift[0];
          end else begin
            r_baud <= r_baud - 1'b1;
          end
        end
        S_DATA: begin
          if (w_baud_zero) begin
            r_baud  <= BAUD_LOAD;
            r_shift <= {1'b0, r_shift[7:1]};
            if (r_bit_idx == 3'd7) begin
              r_state <= S_STOP;
              r_tx    <= 1'b1;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
              r_tx      <= r_shift[1];
            end
          end else begin
            r_baud <= r_baud - 1'b1;
          end
        end
        S_STOP: begin
          // Chaining straight into START keeps back-to-back frames gapless.
          if (w_baud_zero) begin
            if (w_pop) begin
              r_shift <= w_head;
              r_baud  <= BAUD_LOAD;
              r_tx    <= 1'b0;
              r_state <= S_START;
            end else begin
              r_tx    <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end
          end else begin
            r_baud <= r_baud - 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.tx         = r_tx;
  assign bus.full_o     = r_full;
  assign bus.empty_o    = r_empty;
  assign bus.busy_o     = r_busy;
  assign bus.overflow_o = r_overflow;
  assign bus.dbg_state  = r_state;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: two instances (CLK_DIV=4/depth 8 and CLK_DIV=8/depth 4),
// directed writes feed expected-byte queues, a line monitor decodes frames and compares.
module tb_uart_tx_fifo;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  uart_tx_fifo_if bus_a ();
  uart_tx_fifo_if bus_b ();

  uart_tx_fifo #(.CLK_DIV(4), .FIFO_DEPTH_LOG2(3)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  uart_tx_fifo #(.CLK_DIV(8), .FIFO_DEPTH_LOG2(2)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_a_q[$];
  logic [7:0] exp_b_q[$];

  int   frames    [2];
  int   busy_cyc  [2];
  int   busy_rise [2];
  logic busy_prev [2];
  logic mon_act   [2];
  int   mon_cnt   [2];
  logic [7:0] mon_sh [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic get_tx(input int d);
    return (d == 0) ? bus_a.tx : bus_b.tx;
  endfunction

  function automatic logic get_busy(input int d);
    return (d == 0) ? bus_a.busy_o : bus_b.busy_o;
  endfunction

  function automatic logic get_empty(input int d);
    return (d == 0) ? bus_a.empty_o : bus_b.empty_o;
  endfunction

  // Drives one strobe cycle; ack stays high so consecutive calls make back-to-back writes.
  task automatic write_byte(input int d, input logic [7:0] b, input bit accepted);
    if (d == 0) begin
      bus_a.data_i = b;
      bus_a.ack_i  = 1'b1;
      if (accepted) exp_a_q.push_back(b);
    end else begin
      bus_b.data_i = b;
      bus_b.ack_i  = 1'b1;
      if (accepted) exp_b_q.push_back(b);
    end
    @(negedge clk);
  endtask

  task automatic release_ack();
    bus_a.ack_i = 1'b0;
    bus_b.ack_i = 1'b0;
  endtask

  task automatic wait_idle(input int d, input int maxc);
    int n = 0;
    while (!(get_busy(d) == 1'b0 && get_empty(d) == 1'b1) && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("d%0d_idle_within_%0d", d, maxc), (n < maxc), 1);
    repeat (2) @(negedge clk);
  endtask

  // Line monitor: samples mid-bit, decodes each frame and pops the expected byte.
  always @(negedge clk) begin
    logic t;
    int   c;
    int   k;
    logic [7:0] e;
    for (int d = 0; d < 2; d++) begin
      t = get_tx(d);
      c = (d == 0) ? 4 : 8;
      if (rst_n && get_busy(d) && !busy_prev[d]) busy_rise[d]++;
      if (rst_n && get_busy(d)) busy_cyc[d]++;
      busy_prev[d] = get_busy(d);
      if (!rst_n) begin
        mon_act[d] = 1'b0;
      end else if (!mon_act[d]) begin
        if (t == 1'b0) begin
          mon_act[d] = 1'b1;
          mon_cnt[d] = 0;
        end
      end else begin
        mon_cnt[d]++;
      end
      if (rst_n && mon_act[d] && (mon_cnt[d] % c == c / 2)) begin
        k = mon_cnt[d] / c;
        if (k == 0) begin
          chk($sformatf("d%0d_start_bit", d), t, 0);
        end else if (k <= 8) begin
          mon_sh[d] = {t, mon_sh[d][7:1]};
        end else begin
          chk($sformatf("d%0d_stop_bit", d), t, 1);
          mon_act[d] = 1'b0;
          frames[d]++;
          if (d == 0) begin
            if (exp_a_q.size() == 0) chk("d0_frame_expected", exp_a_q.size(), 1);
            else begin
              e = exp_a_q.pop_front();
              chk("d0_frame_byte", mon_sh[d], e);
            end
          end else begin
            if (exp_b_q.size() == 0) chk("d1_frame_expected", exp_b_q.size(), 1);
            else begin
              e = exp_b_q.pop_front();
              chk("d1_frame_byte", mon_sh[d], e);
            end
          end
        end
      end
    end
  end

  initial begin
    logic [9:0] frame;
    int bad;
    int busy_hi;
    int f0;

    for (int d = 0; d < 2; d++) begin
      frames[d] = 0; busy_cyc[d] = 0; busy_rise[d] = 0;
      busy_prev[d] = 1'b0; mon_act[d] = 1'b0; mon_cnt[d] = 0; mon_sh[d] = '0;
    end
    bus_a.data_i = '0; bus_a.ack_i = 1'b0;
    bus_b.data_i = '0; bus_b.ack_i = 1'b0;

    // Reset values
    #2 rst_n = 1'b0;
    #1;
    chk("rst_tx",       bus_a.tx, 1);
    chk("rst_full",     bus_a.full_o, 0);
    chk("rst_empty",    bus_a.empty_o, 1);
    chk("rst_busy",     bus_a.busy_o, 0);
    chk("rst_overflow", bus_a.overflow_o, 0);
    chk("rst_b_tx",     bus_b.tx, 1);
    chk("rst_b_empty",  bus_b.empty_o, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single byte 0xA5: latency and exact bit timing
    write_byte(0, 8'hA5, 1'b1);
    release_ack();
    chk("a5_tx_after_ack_edge", bus_a.tx, 1);
    chk("a5_empty_after_ack_edge", bus_a.empty_o, 0);
    @(negedge clk);
    chk("a5_tx_fall", bus_a.tx, 0);
    chk("a5_busy_rise", bus_a.busy_o, 1);
    frame   = 10'b1101001010;
    bad     = 0;
    busy_hi = 0;
    for (int k = 0; k < 40; k++) begin
      if (bus_a.tx !== frame[k / 4]) bad++;
      if (bus_a.busy_o) busy_hi++;
      @(negedge clk);
    end
    chk("a5_bit_errors", bad, 0);
    chk("a5_busy_cycles", busy_hi, 40);
    chk("a5_busy_after", bus_a.busy_o, 0);
    chk("a5_tx_after", bus_a.tx, 1);
    chk("a5_empty_after", bus_a.empty_o, 1);
    repeat (4) @(negedge clk);

    // Three consecutive writes: contiguous frames
    f0 = frames[0];
    busy_cyc[0]  = 0;
    busy_rise[0] = 0;
    write_byte(0, 8'h00, 1'b1);
    write_byte(0, 8'hFF, 1'b1);
    write_byte(0, 8'h55, 1'b1);
    release_ack();
    wait_idle(0, 200);
    chk("three_busy_cycles", busy_cyc[0], 120);
    chk("three_busy_rises", busy_rise[0], 1);
    chk("three_frames", frames[0] - f0, 3);

    // Write landing exactly on the stop-bit end edge
    write_byte(0, 8'h81, 1'b1);
    release_ack();
    repeat (40) @(negedge clk);
    write_byte(0, 8'h7E, 1'b1);
    release_ack();
    chk("stopend_idle_tx", bus_a.tx, 1);
    chk("stopend_idle_busy", bus_a.busy_o, 0);
    chk("stopend_empty", bus_a.empty_o, 0);
    @(negedge clk);
    chk("stopend_restart_tx", bus_a.tx, 0);
    chk("stopend_restart_busy", bus_a.busy_o, 1);
    wait_idle(0, 100);

    // Pointer wrap on depth-4 instance, one write per frame
    f0 = frames[1];
    for (int i = 0; i < 20; i++) begin
      write_byte(1, 8'h10 + 8'(i), 1'b1);
      release_ack();
      repeat (80) @(negedge clk);
    end
    wait_idle(1, 200);
    chk("wrap_overflow", bus_b.overflow_o, 0);
    chk("wrap_frames", frames[1] - f0, 20);
    chk("wrap_queue_drained", exp_b_q.size(), 0);

    // Overflow: six back-to-back writes into depth 4
    for (int i = 1; i <= 6; i++) begin
      write_byte(1, 8'(i), (i <= 5));
      if (i == 5) begin
        chk("ovf_full_at_4", bus_b.full_o, 1);
        chk("ovf_not_yet", bus_b.overflow_o, 0);
      end
    end
    release_ack();
    chk("ovf_full", bus_b.full_o, 1);
    chk("ovf_set", bus_b.overflow_o, 1);
    wait_idle(1, 500);
    chk("ovf_sticky", bus_b.overflow_o, 1);
    chk("ovf_full_cleared", bus_b.full_o, 0);
    chk("ovf_queue_drained", exp_b_q.size(), 0);

    // Reset during data bit 3 of 0x3C
    f0 = frames[0];
    write_byte(0, 8'h3C, 1'b1);
    release_ack();
    repeat (18) @(negedge clk);
    chk("midrst_in_data", bus_a.dbg_state, 2);
    rst_n = 1'b0;
    #1;
    chk("midrst_tx", bus_a.tx, 1);
    chk("midrst_busy", bus_a.busy_o, 0);
    chk("midrst_empty", bus_a.empty_o, 1);
    chk("midrst_state", bus_a.dbg_state, 0);
    chk("midrst_b_overflow", bus_b.overflow_o, 0);
    exp_a_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    chk("postrst_no_frame", frames[0] - f0, 0);
    chk("postrst_tx", bus_a.tx, 1);
    chk("postrst_busy", bus_a.busy_o, 0);
    chk("postrst_empty", bus_a.empty_o, 1);

    chk("end_queue_a", exp_a_q.size(), 0);
    chk("end_queue_b", exp_b_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL global_timeout actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
